// File: rtl/mem_access_pkg.sv
// Shared definitions for the CPU load/store unit: funct3 codes, FSM states
// and the byte-lane helper used for sub-word stores.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE_W,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    // Byte lanes touched by an access of width funct3[1:0] at offset off.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: pick the byte/half at the word offset and extend it.
module load_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed lane(s) and apply sign or zero extension.
    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and a word-wide memory. Sub-word stores
// are done as read-modify-write; misaligned or illegal requests answer with
// an error response without touching memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_dout
);

    state_t            state_q, state_d;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic [31:0]       rep;
    logic [3:0]        mask;

    assign accept = req_valid && (state_q == ST_IDLE);

    // Classify the incoming request: misalignment, reserved codes, unsigned stores.
    always_comb begin
        req_err = 1'b0;
        case (funct3)
            F3_B:    req_err = 1'b0;
            F3_H:    req_err = addr[0];
            F3_HU:   req_err = addr[0] | req_write;
            F3_W:    req_err = |addr[1:0];
            F3_BU:   req_err = req_write;
            default: req_err = 1'b1;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)            state_d = ST_RESP;
                    else if (!req_write)    state_d = ST_LOAD;
                    else if (funct3 == F3_W) state_d = ST_STORE_W;
                    else                    state_d = ST_RMW_RD;
                end
            end
            ST_LOAD:    state_d = ST_RESP;
            ST_STORE_W: state_d = ST_RESP;
            ST_RMW_RD:  state_d = ST_RMW_WR;
            ST_RMW_WR:  state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Merge store data into the word read back, lane by lane.
    always_comb begin
        mask   = lane_mask(f3_q, addr_q[1:0]);
        rep    = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
        merged = mem_dout;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) merged[8*i +: 8] = rep[8*i +: 8];
        end
    end

    load_align u_load_align (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .word   (mem_dout),
        .data   (load_data)
    );

    // State, latched request fields, merge buffer and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= wdata;
                err_q   <= req_err;
            end
            if (state_q == ST_LOAD)   rdata_q <= load_data;
            if (state_q == ST_RMW_RD) merge_q <= merged;
        end
    end

    // Strobes are gated by reset so an aborted access never reaches memory.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign rdata      = rdata_q;
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_din    = (state_q == ST_STORE_W) ? wdata_q : merge_q;
    assign mem_read   = !reset && ((state_q == ST_LOAD) || (state_q == ST_RMW_RD));
    assign mem_write  = !reset && ((state_q == ST_STORE_W) || (state_q == ST_RMW_WR));

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, CPU-side and memory-side address width.
REQ-002 SHALL have clk: input, 1, clock; all state updates on posedge.
REQ-003 SHALL have reset: input, 1, reset, synchronous, active-high.
REQ-004 SHALL have req_valid: input, 1, CPU requests an access this cycle.
REQ-005 SHALL have req_ready: output, 1, unit can accept a request (state IDLE).
REQ-006 SHALL have req_write: input, 1, 1 = store, 0 = load.
REQ-007 SHALL have funct3: input, 3, RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have addr: input, ADDR_W, byte address.
REQ-009 SHALL have wdata: input, 32, store data, right-aligned.
REQ-010 SHALL have resp_valid: output, 1, one-cycle completion pulse.
REQ-011 SHALL have resp_err: output, 1, qualifies resp_valid; misaligned or illegal funct3.
REQ-012 SHALL have rdata: output, 32, extended load result; held until the next load response.
REQ-013 SHALL have mem_addr: output, ADDR_W, word-aligned address ({addr[31:2],2'b00}).
REQ-014 SHALL have mem_din: output, 32, full word to write.
REQ-015 SHALL have mem_read: output, 1, read strobe; mem_dout is valid in the same cycle.
REQ-016 SHALL have mem_write: output, 1, write strobe; the word is written at the next posedge.
REQ-017 SHALL have mem_dout: input, 32, combinational read data from the word memory.

Function
REQ-018 SHALL accept a request on a posedge with req_valid && req_ready, latching req_write, funct3, addr and wdata.
REQ-019 SHALL implement the FSM IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP.
REQ-020 SHALL decide the next state at accept as follows.
- Error to RESP with the error flag set: addr[0]≠0 for H/HU; addr[1:0]≠0 for W; funct3 of 011, 110 or 111; or BU/HU on a store.
- Otherwise: load to LOAD; SW to STORE_W; SB/SH to RMW_RD.
REQ-021 SHALL, in LOAD, assert mem_read, select the byte/half at addr[1:0], extend it (sign-extend for B/H, zero-extend for BU/HU, word unchanged), register it into rdata, and go to RESP.
REQ-022 SHALL, in RMW_RD, assert mem_read, merge wdata[7:0] or wdata[15:0] into mem_dout at the byte lane(s) given by addr[1:0], register the merged word, and go to RMW_WR.
REQ-023 SHALL, in STORE_W or RMW_WR, assert mem_write for exactly one cycle with mem_din = wdata or the merged word, then go to RESP.
REQ-024 SHALL, in RESP, drive resp_valid=1 for one cycle with resp_err = the latched error flag, then go to IDLE.
REQ-025 SHALL have these accept-to-resp_valid latencies: error 1 cycle; load 2; SW 2; SB/SH 3.
REQ-026 SHALL drive req_ready=1 only in IDLE; req_valid outside IDLE is ignored and not queued.
REQ-027 SHALL keep mem_read and mem_write mutually exclusive and both 0 in IDLE and RESP.
REQ-028 SHALL never touch memory for an erroring request, and SHALL leave rdata unchanged on store or error responses.

Reset
REQ-029 SHALL, on a posedge with reset=1, enter IDLE and clear rdata, resp_valid, resp_err, the latched fields and the merge buffer.
REQ-030 SHALL force mem_write=0 and mem_read=0 combinationally whenever reset=1.
REQ-031 SHALL abort an access in flight when reset is asserted mid-operation: no write is issued and no response is produced.

Structure
REQ-032 SHALL take from the shared package mem_access_pkg: funct3 constants F3_B/H/W/BU/HU, the state enum, and the lane-select helper.
REQ-033 SHALL place load byte/half selection and extension in one combinational sub-module, load_align.

Verification
(Memory pre-loaded with word[4] (byte addr 0x10) = 0x8070_F0A5.)
REQ-034 SHALL cover: LB 0x10 -> rdata 0xFFFF_FFA5 at accept+2; LBU 0x13 -> 0x0000_0080.
REQ-035 SHALL cover: LH 0x12 -> 0xFFFF_8070; LHU 0x10 -> 0x0000_F0A5.
REQ-036 SHALL cover: SB 0x11 with wdata 0x1234_5677 -> one mem_write cycle and word[4] = 0x8070_77A5; SH 0x12 with wdata 0xBEEF -> 0xBEEF_77A5; resp at accept+3.
REQ-037 SHALL cover: SW 0x22 and LH 0x13 -> resp_valid=1, resp_err=1 at accept+1, no mem_read/mem_write, rdata unchanged.
REQ-038 SHALL cover: reset asserted in the RMW_RD cycle -> no mem_write ever, no resp_valid, req_ready=1 the cycle after reset deasserts.
REQ-039 SHALL cover: req_valid held high across two requests -> the second is accepted only in the cycle after RESP, with one resp_valid per request.
